fifo_ctrl: RTL and testbench

- Control stage that drives the 8×4 register-file storage of the FIFO lab.
- Turns enqueue/dequeue button levels into single-cycle operations and manages head/tail pointers and occupancy.
- Drives the register-file write port and read port 0, and registers dequeued data.
- Runs a free-running scan over read port 1, so the display stage downstream can show every slot with a per-slot valid flag.

---
 rtl/fifo_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy control for the 8x4 register-file FIFO.
// Edge-detects button levels and scans read port 1 for the display.
module fifo_ctrl #(
    parameter int WIDTH     = 4,
    parameter int WORD_LINE = 3,
    parameter int SCAN_DIV  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq,
    input  logic                 deq,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out,
    output logic                 full,
    output logic                 emp,
    output logic                 rf_we,
    output logic [WORD_LINE-1:0] rf_wa,
    output logic [WIDTH-1:0]     rf_wd,
    output logic [WORD_LINE-1:0] rf_ra0,
    input  logic [WIDTH-1:0]     rf_rd0,
    output logic [WORD_LINE-1:0] rf_ra1,
    input  logic [WIDTH-1:0]     rf_rd1,
    output logic [WIDTH-1:0]     scan_data,
    output logic                 scan_valid
);

    localparam int DEPTH = 1 << WORD_LINE;
    localparam int CW    = WORD_LINE + 1;
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WORD_LINE-1:0] r_head;
    logic [WORD_LINE-1:0] r_tail;
    logic [CW-1:0]        r_count;
    logic [DEPTH-1:0]     r_valid;
    logic                 r_enq_q;
    logic                 r_deq_q;
    logic                 r_live;
    logic [WIDTH-1:0]     r_out;
    logic [WORD_LINE-1:0] r_scan;
    logic [PW-1:0]        r_pre;

    logic w_enq_p;
    logic w_deq_p;
    logic w_do_enq;
    logic w_do_deq;

    // r_live masks the first cycle after reset so a level held
    // through reset is sampled, not mistaken for a fresh press.
    assign w_enq_p  = r_live & enq & ~r_enq_q;
    assign w_deq_p  = r_live & deq & ~r_deq_q;
    assign w_do_enq = w_enq_p & ~full;
    assign w_do_deq = w_deq_p & ~emp;

    assign full       = (r_count == CNT_FULL);
    assign emp        = (r_count == '0);
    assign out        = r_out;
    assign rf_we      = w_do_enq;
    assign rf_wa      = r_tail;
    assign rf_wd      = in;
    assign rf_ra0     = r_head;
    assign rf_ra1     = r_scan;
    assign scan_data  = rf_rd1;
    assign scan_valid = r_valid[r_scan];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_enq_q <= 1'b0;
            r_deq_q <= 1'b0;
            r_live  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_live  <= 1'b1;
            r_enq_q <= enq;
            r_deq_q <= deq;
            if (w_do_deq) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
                r_out           <= rf_rd0;
            end
            if (w_do_enq) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            unique case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_pre  <= '0;
        end else if (r_pre == PRE_MAX) begin
            r_pre  <= '0;
            r_scan <= r_scan + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed vector table plus hand sequences for fifo_ctrl,
// with a behavioural 8x4 register file attached.
module tb_fifo_ctrl;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq = 1'b0;
    logic       deq = 1'b0;
    logic [3:0] in  = '0;
    logic [3:0] out;
    logic       full, emp, rf_we;
    logic [2:0] rf_wa, rf_ra0, rf_ra1;
    logic [3:0] rf_wd, rf_rd0, rf_rd1, scan_data;
    logic       scan_valid;

    logic [3:0] mem [8];

    int n_chk  = 0;
    int n_pass = 0;

    fifo_ctrl #(.WIDTH(4), .WORD_LINE(3), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .in(in),
        .out(out), .full(full), .emp(emp),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_ra0(rf_ra0), .rf_rd0(rf_rd0),
        .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
        .scan_data(scan_data), .scan_valid(scan_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) mem[rf_wa] <= rf_wd;
    assign rf_rd0 = mem[rf_ra0];
    assign rf_rd1 = mem[rf_ra1];

    typedef struct {
        logic       e;
        logic       d;
        logic [3:0] din;
        logic       we;
        logic [2:0] wa;
        logic [3:0] q;
        logic       f;
        logic       em;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void add(input logic e, input logic d,
                                input logic [3:0] din, input logic we,
                                input logic [2:0] wa, input logic [3:0] q,
                                input logic f, input logic em);
        vec_t v;
        v.e = e; v.d = d; v.din = din; v.we = we;
        v.wa = wa; v.q = q; v.f = f; v.em = em;
        vq.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            enq = vq[i].e;
            deq = vq[i].d;
            in  = vq[i].din;
            #1;
            chk($sformatf("%s[%0d].we", tag, i), int'(rf_we), int'(vq[i].we));
            chk($sformatf("%s[%0d].wa", tag, i), int'(rf_wa), int'(vq[i].wa));
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].out", tag, i), int'(out), int'(vq[i].q));
            chk($sformatf("%s[%0d].full", tag, i), int'(full), int'(vq[i].f));
            chk($sformatf("%s[%0d].emp", tag, i), int'(emp), int'(vq[i].em));
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_check(input string tag, input logic [7:0] mask);
        logic [2:0] idx;
        logic [7:0] m;
        idx = rf_ra1;
        m   = mask;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s.ra1[%0d]", tag, k), int'(rf_ra1), int'(idx));
            chk($sformatf("%s.valid[%0d]", tag, idx), int'(scan_valid), int'(m[idx]));
            repeat (SD) @(negedge clk);
            idx = idx + 3'd1;
        end
    endtask

    task automatic press(input logic [3:0] v, input logic [2:0] wa,
                         input logic f, input logic [3:0] q);
        add(1, 0, v, 1, wa, q, f, 0);
        add(0, 0, 0, 0, wa + 3'd1, q, f, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;

        do_reset();
        chk("rst.emp", int'(emp), 1);
        chk("rst.full", int'(full), 0);
        chk("rst.out", int'(out), 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        run_table("idle");
        scan_check("idle", 8'h00);

        // three presses, the third held for 10 cycles
        press(4'h1, 3'd0, 0, 0);
        press(4'h2, 3'd1, 0, 0);
        add(1, 0, 4'h3, 1, 3'd2, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 0, 4'h3, 0, 3'd3, 0, 0, 0);
        add(0, 0, 0, 0, 3'd3, 0, 0, 0);
        run_table("enq3");
        scan_check("enq3", 8'h07);

        // fill, reject a 9th, drain
        do_reset();
        for (int i = 0; i < 8; i++)
            press(4'(8 + i), 3'(i), (i == 7), 0);
        add(1, 0, 4'h6, 0, 3'd0, 0, 1, 0);
        add(0, 0, 0, 0, 3'd0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 1, 0, 0, 3'd0, 4'(8 + i), 0, (i == 7));
            add(0, 0, 0, 0, 3'd0, 4'(8 + i), 0, (i == 7));
        end
        run_table("full");

        // pointer wrap
        do_reset();
        for (int i = 0; i < 6; i++) press(4'(i + 1), 3'(i), 0, 0);
        for (int i = 0; i < 6; i++) begin
            add(0, 1, 0, 0, 3'd6, 4'(i + 1), 0, (i == 5));
            add(0, 0, 0, 0, 3'd6, 4'(i + 1), 0, (i == 5));
        end
        for (int i = 0; i < 4; i++) press(4'(9 + i), 3'(6 + i), 0, 4'h6);
        for (int i = 0; i < 4; i++) begin
            add(0, 1, 0, 0, 3'd2, 4'(9 + i), 0, (i == 3));
            add(0, 0, 0, 0, 3'd2, 4'(9 + i), 0, (i == 3));
        end
        run_table("wrap");

        // simultaneous pulses, mid-occupancy then empty
        do_reset();
        press(4'h1, 3'd0, 0, 0);
        press(4'h2, 3'd1, 0, 0);
        add(1, 1, 4'h5, 1, 3'd2, 4'h1, 0, 0);
        add(0, 0, 0, 0, 3'd3, 4'h1, 0, 0);
        run_table("both");
        scan_check("both", 8'h06);
        add(0, 1, 0, 0, 3'd3, 4'h2, 0, 0);
        add(0, 0, 0, 0, 3'd3, 4'h2, 0, 0);
        add(0, 1, 0, 0, 3'd3, 4'h5, 0, 1);
        add(0, 0, 0, 0, 3'd3, 4'h5, 0, 1);
        add(1, 1, 4'h7, 1, 3'd3, 4'h5, 0, 0);
        add(0, 0, 0, 0, 3'd4, 4'h5, 0, 0);
        add(0, 1, 0, 0, 3'd4, 4'h7, 0, 1);
        add(0, 0, 0, 0, 3'd4, 4'h7, 0, 1);
        run_table("bothemp");

        // simultaneous pulses when full: dequeue only, count drops to 7
        do_reset();
        for (int i = 0; i < 8; i++) press(4'(i + 1), 3'(i), (i == 7), 0);
        add(1, 1, 4'h4, 0, 3'd0, 4'h1, 0, 0);
        add(0, 0, 0, 0, 3'd0, 4'h1, 0, 0);
        add(1, 0, 4'h9, 1, 3'd0, 4'h1, 1, 0);
        add(0, 0, 0, 0, 3'd1, 4'h1, 1, 0);
        run_table("bothfull");

        // reset during a held enqueue
        do_reset();
        press(4'h1, 3'd0, 0, 0);
        press(4'h2, 3'd1, 0, 0);
        press(4'h3, 3'd2, 0, 0);
        add(1, 0, 4'h4, 1, 3'd3, 0, 0, 0);
        run_table("pre");
        #3 rst = 1'b1;
        #1;
        chk("mid.emp", int'(emp), 1);
        chk("mid.full", int'(full), 0);
        chk("mid.out", int'(out), 0);
        chk("mid.we", int'(rf_we), 0);
        chk("mid.wa", int'(rf_wa), 0);
        chk("mid.ra0", int'(rf_ra0), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("held[%0d].we", i), int'(rf_we), 0);
            chk($sformatf("held[%0d].emp", i), int'(emp), 1);
            @(negedge clk);
        end
        enq = 1'b0;
        scan_check("post", 8'h00);
        add(1, 0, 4'hA, 1, 3'd0, 0, 0, 0);
        add(0, 0, 0, 0, 3'd1, 0, 0, 0);
        run_table("repress");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
